// File: rtl/tiro_nave.sv
// Player-ship projectile: one shot in flight, rises PASSO pixels per movement tick, then a cooldown.
// Define TIRO_AUTO_EN to make a held fire button launch repeatedly; by default a fresh press is required.
module tiro_nave #(
  parameter int CLK_DIV       = 320000,
  parameter int PASSO         = 4,
  parameter int Y_TOPO        = 8,
  parameter int OFFSET_X      = 16,
  parameter int RECARGA_TICKS = 10
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       pausa,
  input  logic       reiniciarJogo,
  input  logic       disparo,
  input  logic [9:0] x_nave,
  input  logic [9:0] y_nave,
  input  logic       acerto,
  output logic [9:0] x_bola_nave,
  output logic [9:0] y_bola_nave,
  output logic       ativa,
  output logic       disparou
);

  // state   | meaning
  // OCIOSO  | no shot, parked at (0,0), waiting for a fire request
  // VOANDO  | shot in flight, rising on each active tick
  // RECARGA | shot retired, counting cooldown ticks
  typedef enum logic [1:0] {OCIOSO, VOANDO, RECARGA} estado_t;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RW = (RECARGA_TICKS > 1) ? $clog2(RECARGA_TICKS) : 1;
  localparam logic [DW-1:0] DIV_FIM = DW'(CLK_DIV - 1);
  localparam logic [RW-1:0] REC_FIM = (RECARGA_TICKS > 0) ? RW'(RECARGA_TICKS - 1) : '0;
  localparam logic [9:0]  X_MAX   = 10'd639;
  localparam logic [9:0]  Y_MIN   = 10'(Y_TOPO);
  localparam logic [9:0]  Y_LIM   = 10'(Y_TOPO + PASSO);
  localparam logic [9:0]  PASSO_V = 10'(PASSO);
  localparam logic [10:0] OFF_X   = 11'(OFFSET_X);

  estado_t       estado, estado_n;
  logic [DW-1:0] cont_div;
  logic [RW-1:0] cont_rec, cont_rec_n;
  logic          disparo_q;
  logic [9:0]    x_n, y_n;
  logic          ativa_n, disparou_n;
  logic          tick, tick_ativo, pedido;
  logic [10:0]   x_soma;
  logic [9:0]    x_lanc, y_lanc;

  assign tick       = (cont_div == DIV_FIM);
  assign tick_ativo = tick & ~pausa;

`ifdef TIRO_AUTO_EN
  assign pedido = disparo;
`else
  assign pedido = disparo & ~disparo_q;
`endif

  // Muzzle x is summed at 11 bits so a ship near the right edge clamps instead of wrapping.
  assign x_soma = {1'b0, x_nave} + OFF_X;
  assign x_lanc = (x_soma > 11'd639) ? X_MAX : x_soma[9:0];
  assign y_lanc = (y_nave <= Y_MIN) ? Y_MIN : (y_nave - 10'd1);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      estado      <= OCIOSO;
      cont_div    <= '0;
      cont_rec    <= '0;
      disparo_q   <= 1'b0;
      x_bola_nave <= '0;
      y_bola_nave <= '0;
      ativa       <= 1'b0;
      disparou    <= 1'b0;
    end else if (reiniciarJogo) begin
      estado      <= OCIOSO;
      cont_div    <= '0;
      cont_rec    <= '0;
      disparo_q   <= 1'b0;
      x_bola_nave <= '0;
      y_bola_nave <= '0;
      ativa       <= 1'b0;
      disparou    <= 1'b0;
    end else begin
      estado      <= estado_n;
      cont_div    <= tick ? '0 : (cont_div + DW'(1));
      cont_rec    <= cont_rec_n;
      disparo_q   <= disparo;
      x_bola_nave <= x_n;
      y_bola_nave <= y_n;
      ativa       <= ativa_n;
      disparou    <= disparou_n;
    end
  end

  always_comb begin
    estado_n   = estado;
    cont_rec_n = cont_rec;
    x_n        = x_bola_nave;
    y_n        = y_bola_nave;
    ativa_n    = ativa;
    disparou_n = 1'b0;
    case (estado)
      OCIOSO: begin
        x_n     = '0;
        y_n     = '0;
        ativa_n = 1'b0;
        if (pedido && !pausa) begin
          estado_n   = VOANDO;
          x_n        = x_lanc;
          y_n        = y_lanc;
          ativa_n    = 1'b1;
          disparou_n = 1'b1;
        end
      end
      VOANDO: begin
        // A hit outranks movement, so a hit on a tick edge never moves the shot.
        if (acerto || (tick_ativo && (y_bola_nave < Y_LIM))) begin
          estado_n   = RECARGA;
          cont_rec_n = '0;
          x_n        = '0;
          y_n        = '0;
          ativa_n    = 1'b0;
        end else if (tick_ativo) begin
          y_n = y_bola_nave - PASSO_V;
        end
      end
      RECARGA: begin
        x_n     = '0;
        y_n     = '0;
        ativa_n = 1'b0;
        if (RECARGA_TICKS == 0) begin
          estado_n = OCIOSO;
        end else if (tick_ativo) begin
          if (cont_rec == REC_FIM) estado_n = OCIOSO;
          else cont_rec_n = cont_rec + RW'(1);
        end
      end
      default: begin
        estado_n = OCIOSO;
        x_n      = '0;
        y_n      = '0;
        ativa_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_tiro_nave.sv
// Randomized and directed bench for tiro_nave against a behavioural shot model.
module tb_tiro_nave;
  localparam int CLK_DIV       = 4;
  localparam int PASSO         = 4;
  localparam int Y_TOPO        = 8;
  localparam int OFFSET_X      = 16;
  localparam int RECARGA_TICKS = 2;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       pausa = 1'b0;
  logic       reiniciarJogo = 1'b0;
  logic       disparo = 1'b0;
  logic [9:0] x_nave = '0;
  logic [9:0] y_nave = '0;
  logic       acerto = 1'b0;
  logic [9:0] x_bola_nave, y_bola_nave;
  logic       ativa, disparou;

  tiro_nave #(
    .CLK_DIV(CLK_DIV), .PASSO(PASSO), .Y_TOPO(Y_TOPO),
    .OFFSET_X(OFFSET_X), .RECARGA_TICKS(RECARGA_TICKS)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .pausa(pausa), .reiniciarJogo(reiniciarJogo),
    .disparo(disparo), .x_nave(x_nave), .y_nave(y_nave), .acerto(acerto),
    .x_bola_nave(x_bola_nave), .y_bola_nave(y_bola_nave), .ativa(ativa), .disparou(disparou)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_total = 0;
  int n_ok = 0;

  // Reference model: cycles since clear, whether a shot flies, its position, and cooldown ticks left.
  int m_ciclos;
  bit m_dq, m_voa, m_rec, m_disp, m_act;
  int m_falta, m_x, m_y;
  int n_pulsos, m_pulsos;

  task automatic check(input string tag, input int obs, input int esp);
    n_total++;
    if (obs != esp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, esp, $time);
    else n_ok++;
  endtask

  task automatic modelo_zera();
    m_ciclos = 0; m_dq = 0; m_voa = 0; m_rec = 0; m_disp = 0; m_act = 0;
    m_falta = 0; m_x = 0; m_y = 0;
  endtask

  task automatic modelo_passo();
    bit tk, pede;
    int yl;
    if (reiniciarJogo) begin
      modelo_zera();
      return;
    end
    tk = ((m_ciclos % CLK_DIV) == CLK_DIV - 1);
    m_ciclos++;
`ifdef TIRO_AUTO_EN
    pede = disparo;
`else
    pede = disparo && !m_dq;
`endif
    m_dq   = disparo;
    m_act  = tk && !pausa;
    m_disp = 0;
    if (m_voa) begin
      if (acerto || (m_act && (m_y - PASSO < Y_TOPO))) begin
        m_voa = 0; m_rec = 1; m_falta = RECARGA_TICKS;
      end else if (m_act) begin
        m_y = m_y - PASSO;
      end
    end else if (m_rec) begin
      if (RECARGA_TICKS == 0) m_rec = 0;
      else if (m_act) begin
        m_falta--;
        if (m_falta == 0) m_rec = 0;
      end
    end else if (pede && !pausa) begin
      m_voa  = 1;
      m_disp = 1;
      m_x    = int'(x_nave) + OFFSET_X;
      if (m_x > 639) m_x = 639;
      yl  = int'(y_nave) - 1;
      m_y = (yl < Y_TOPO) ? Y_TOPO : yl;
    end
  endtask

  task automatic compara_saidas(input string etapa);
    check({etapa, ".ativa"}, int'(ativa), int'(m_voa));
    check({etapa, ".x"}, int'(x_bola_nave), m_voa ? m_x : 0);
    check({etapa, ".y"}, int'(y_bola_nave), m_voa ? m_y : 0);
    check({etapa, ".disparou"}, int'(disparou), int'(m_disp));
  endtask

  task automatic passo();
    modelo_passo();
    @(posedge CLOCK_50);
    #1;
    if (disparou) n_pulsos++;
    if (m_disp) m_pulsos++;
    compara_saidas("ciclo");
  endtask

  task automatic espera_ticks(input int n);
    int k = 0;
    int lim = 0;
    while (k < n && lim < 1000) begin
      passo();
      if (m_act) k++;
      lim++;
    end
    if (lim >= 1000) check("timeout_ticks", 0, 1);
  endtask

  task automatic espera_ocioso();
    int lim = 0;
    while ((m_voa || m_rec) && lim < 2000) begin
      passo();
      lim++;
    end
    if (lim >= 2000) check("timeout_ocioso", 0, 1);
  endtask

  // Called just after an edge; asserts reset mid-cycle and releases it well before the next edge.
  task automatic reset_assinc();
    #2;
    reset = 1'b1;
    #1;
    modelo_zera();
    check("rst_assinc.ativa", int'(ativa), 0);
    check("rst_assinc.x", int'(x_bola_nave), 0);
    check("rst_assinc.y", int'(y_bola_nave), 0);
    check("rst_assinc.disparou", int'(disparou), 0);
    #2;
    reset = 1'b0;
  endtask

  task automatic lanca();
    espera_ocioso();
    disparo = 1'b0;
    passo();
    disparo = 1'b1;
    passo();
    disparo = 1'b0;
  endtask

  initial begin
    int nt, yp;
    modelo_zera();
    n_pulsos = 0; m_pulsos = 0;
    #12;
    check("reset.ativa", int'(ativa), 0);
    check("reset.x", int'(x_bola_nave), 0);
    check("reset.y", int'(y_bola_nave), 0);
    check("reset.disparou", int'(disparou), 0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    modelo_zera();
    repeat (3) passo();

    // launch and climb
    x_nave = 10'd300; y_nave = 10'd440;
    disparo = 1'b1;
    passo();
    check("lanc.x", int'(x_bola_nave), 316);
    check("lanc.y", int'(y_bola_nave), 439);
    check("lanc.pulso", int'(disparou), 1);
    disparo = 1'b0;
    passo();
    nt = m_act ? 1 : 0;
    check("lanc.pulso_unico", int'(disparou), 0);
    espera_ticks(3 - nt);
    check("lanc.y_3ticks", int'(y_bola_nave), 427);

    // hit, then cooldown ignores a press
    acerto = 1'b1;
    passo();
    acerto = 1'b0;
    check("acerto.ativa", int'(ativa), 0);
    check("acerto.y", int'(y_bola_nave), 0);
    espera_ticks(1);
    disparo = 1'b1;
    passo();
    check("recarga.ignora", int'(ativa), 0);
    disparo = 1'b0;
    espera_ocioso();
    disparo = 1'b1;
    passo();
    check("recarga.relanca", int'(ativa), 1);
    disparo = 1'b0;

    // pause freezes flight, hit still retires
    passo();
    pausa = 1'b1;
    yp = m_y;
    for (int i = 0; i < 20; i++) begin
      disparo = (i >= 5 && i < 9);
      passo();
    end
    disparo = 1'b0;
    check("pausa.y", int'(y_bola_nave), yp);
    acerto = 1'b1;
    passo();
    acerto = 1'b0;
    check("pausa.acerto", int'(ativa), 0);
    pausa = 1'b0;
    espera_ocioso();
    pausa = 1'b1;
    disparo = 1'b1;
    passo(); passo();
    disparo = 1'b0;
    pausa = 1'b0;
    passo(); passo();
    check("pausa.sem_fila", int'(ativa), 0);

    // clamp, async reset, synchronous clear
    x_nave = 10'd630;
    lanca();
    check("clamp.x", int'(x_bola_nave), 639);
    passo();
    reset_assinc();
    repeat (2) passo();
    lanca();
    passo();
    reiniciarJogo = 1'b1;
    passo();
    check("reinicia.ativa", int'(ativa), 0);
    check("reinicia.x", int'(x_bola_nave), 0);
    reiniciarJogo = 1'b0;
    passo();
    disparo = 1'b1;
    reiniciarJogo = 1'b1;
    passo();
    check("reinicia_vs_disparo.ativa", int'(ativa), 0);
    check("reinicia_vs_disparo.pulso", int'(disparou), 0);
    reiniciarJogo = 1'b0;
    disparo = 1'b0;
    passo();

    // top edge and launch floor
    x_nave = 10'd100; y_nave = 10'd13;
    lanca();
    check("topo.y0", int'(y_bola_nave), 12);
    espera_ocioso();
    y_nave = 10'd5;
    lanca();
    check("topo.piso", int'(y_bola_nave), Y_TOPO);
    espera_ocioso();

    // held button
`ifdef TIRO_AUTO_EN
    y_nave = 10'd21;
`else
    y_nave = 10'd300;
`endif
    passo();
    n_pulsos = 0; m_pulsos = 0;
    disparo = 1'b1;
    repeat (200) passo();
    disparo = 1'b0;
`ifdef TIRO_AUTO_EN
    check("segurado.pulsos", n_pulsos, m_pulsos);
`else
    check("segurado.pulsos", n_pulsos, 1);
`endif

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) disparo = ~disparo;
      acerto = ($urandom_range(0, 30) == 0);
      if ($urandom_range(0, 40) == 0) pausa = ~pausa;
      reiniciarJogo = ($urandom_range(0, 300) == 0);
      if ($urandom_range(0, 50) == 0) begin
        x_nave = 10'($urandom_range(0, 1023));
        y_nave = 10'($urandom_range(0, 1023));
      end
      passo();
      if ($urandom_range(0, 500) == 0) reset_assinc();
    end

    $display("%0d/%0d checks passed", n_ok, n_total);
    $finish;
  end
endmodule
